// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder.
// Word-wide storage array without byte enables; partial writes become a
// read-modify-write through the MERGE state. Responses are held until the
// consumer accepts them.
// Optional feature macro: DMEM_RANGE_CHECK_EN (address range checking with
// rsp_err reporting). When it is undefined, addresses alias modulo DMEM_SIZE.
// INIT_FILE names the image that the implementation flow binds to the array.
module dmem_responder #(
    parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
    parameter int unsigned DMEM_SIZE = 32768,
    parameter string       INIT_FILE = "target/data.mif"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [29:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH    = DMEM_SIZE / 4;
    localparam int          IDX_W    = $clog2(DMEM_SIZE) - 2;
    localparam bit          HAS_INIT = (INIT_FILE != "");

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rd_q, rd_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem_word;
    logic [31:0]      merged;
    logic             mem_we;
    logic [31:0]      mem_wdata;
    logic             in_range;
    logic             unused_cfg;

    // Low word-address bits select the array entry; higher bits alias.
    assign idx      = addr_q[IDX_W-1:0];
    assign mem_word = mem[idx];

    // Upper address bits and configuration only matter in some builds.
    assign unused_cfg = ^{addr_q[29:IDX_W], DMEM_BASE, HAS_INIT};

`ifdef DMEM_RANGE_CHECK_EN
    logic [31:0] byte_off;

    // In range when the 1 MiB window matches the base and the offset fits.
    assign byte_off = {12'h000, addr_q[17:0], 2'b00};
    assign in_range = (addr_q[29:18] == DMEM_BASE[31:20]) && (byte_off < DMEM_SIZE);
`else
    assign in_range = 1'b1;
`endif

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Byte merge: strobed bytes from the write data, the rest from the read register.
    always_comb begin
        merged = rd_q;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Array write enable; a reset arriving before the write edge suppresses it.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        if (!rst) begin
            if (state_q == ACCESS && we_q && in_range && wstrb_q == 4'b1111) begin
                mem_we    = 1'b1;
                mem_wdata = wdata_q;
            end else if (state_q == MERGE) begin
                mem_we    = 1'b1;
                mem_wdata = merged;
            end
        end
    end

    // Storage array; deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= mem_wdata;
        end
    end

    // Next-state and response computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rd_d        = rd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!in_range) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                    state_d     = RESP;
                end else begin
                    rd_d = mem_word;
                    if (!we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = rd_d;
                        state_d     = RESP;
                    end else if (wstrb_q == 4'b1111 || wstrb_q == 4'b0000) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = 32'h0;
                        state_d     = RESP;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'h0;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'h0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= 30'h0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            rd_q        <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: reset state, full/partial/no-op
// writes, reads, response back-pressure, reset during MERGE and the
// out-of-range / aliasing behaviour selected by DMEM_RANGE_CHECK_EN.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [29:0] req_addr;
   logic        req_we;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;
   int lat;

   dmem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_we    (req_we),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and reports tag/observed/expected on a miss.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Issues one request and waits (bounded) until the response is presented.
   // lat is the number of cycles after the handshake cycle, or -1 on timeout.
   task automatic applyStimulus(input logic [31:0] byte_addr, input logic we,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                output int lat_o);
      int cyc;
      @(negedge clk);
      checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
      req_addr  = byte_addr[31:2];
      req_we    = we;
      req_wdata = wdata;
      req_wstrb = wstrb;
      req_valid = 1'b1;
      @(posedge clk);
      lat_o = -1;
      cyc   = 0;
      while (lat_o < 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         req_valid = 1'b0;
         if (rsp_valid) lat_o = cyc;
      end
   endtask

   // Accepts the pending response and checks that it is withdrawn.
   task automatic consumeResponse(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput(tag, 32'(rsp_valid), 32'd0);
   endtask

   // Read with the normal two-cycle latency and an expected data word.
   task automatic readCheck(input string tag, input logic [31:0] byte_addr, input logic [31:0] expected);
      int l;
      applyStimulus(byte_addr, 1'b0, 32'h0, 4'h0, l);
      checkOutput({tag, "_lat"}, 32'(l), 32'd2);
      checkOutput(tag, rsp_rdata, expected);
      checkOutput({tag, "_err"}, 32'(rsp_err), 32'd0);
      consumeResponse({tag, "_drop"});
   endtask

   // Write with an expected latency and a zero-data, no-error response.
   task automatic writeCheck(input string tag, input logic [31:0] byte_addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input int exp_lat);
      int l;
      applyStimulus(byte_addr, 1'b1, wdata, wstrb, l);
      checkOutput({tag, "_lat"}, 32'(l), 32'(exp_lat));
      checkOutput({tag, "_rdata"}, rsp_rdata, 32'h0);
      checkOutput({tag, "_err"}, 32'(rsp_err), 32'd0);
      consumeResponse({tag, "_drop"});
   endtask

   // Directed stimulus sequence.
   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = 30'h0;
      req_we    = 1'b0;
      req_wdata = 32'h0;
      req_wstrb = 4'h0;
      rsp_ready = 1'b0;

      $display("[TB] reset checks");
      @(negedge clk);
      checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_err", 32'(rsp_err), 32'd0);
      checkOutput("reset_rdata", rsp_rdata, 32'h0);

      $display("[TB] full write then read-back");
      writeCheck("full_wr", 32'h0010_0000, 32'hDEAD_BEEF, 4'b1111, 2);
      readCheck("full_rd", 32'h0010_0000, 32'hDEAD_BEEF);

      $display("[TB] partial writes");
      writeCheck("seed_wr", 32'h0010_0004, 32'h1122_3344, 4'b1111, 2);
      writeCheck("part_wr", 32'h0010_0004, 32'h00AB_0000, 4'b0100, 3);
      readCheck("part_rd", 32'h0010_0004, 32'h11AB_3344);
      writeCheck("part2_wr", 32'h0010_0004, 32'hEE00_00DD, 4'b1001, 3);
      readCheck("part2_rd", 32'h0010_0004, 32'hEEAB_33DD);

      $display("[TB] response back-pressure");
      applyStimulus(32'h0010_0000, 1'b0, 32'h0, 4'h0, lat);
      checkOutput("hold_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
         checkOutput("hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
         checkOutput("hold_ready", 32'(req_ready), 32'd0);
      end
      consumeResponse("hold_drop");

      $display("[TB] reset during merge");
      writeCheck("abort_seed", 32'h0010_0008, 32'hA5A5_A5A5, 4'b1111, 2);
      @(negedge clk);
      req_addr  = 30'h0004_0002;
      req_we    = 1'b1;
      req_wdata = 32'h0000_00FF;
      req_wstrb = 4'b0001;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_valid", 32'(rsp_valid), 32'd0);
      checkOutput("abort_ready", 32'(req_ready), 32'd1);
      readCheck("abort_rd", 32'h0010_0008, 32'hA5A5_A5A5);

      $display("[TB] no-op write");
      writeCheck("noop_wr", 32'h0010_0000, 32'h1234_5678, 4'b0000, 2);
      readCheck("noop_rd", 32'h0010_0000, 32'hDEAD_BEEF);

      $display("[TB] out-of-window write");
      applyStimulus(32'h0020_0000, 1'b1, 32'hCAFE_F00D, 4'b1111, lat);
      checkOutput("oor_lat", 32'(lat), 32'd2);
      checkOutput("oor_rdata", rsp_rdata, 32'h0);
`ifdef DMEM_RANGE_CHECK_EN
      checkOutput("oor_err", 32'(rsp_err), 32'd1);
      consumeResponse("oor_drop");
      readCheck("oor_rd", 32'h0010_0000, 32'hDEAD_BEEF);
`else
      checkOutput("oor_err", 32'(rsp_err), 32'd0);
      consumeResponse("oor_drop");
      readCheck("alias_rd", 32'h0010_0000, 32'hCAFE_F00D);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
